ip_fifo_ctrl_mch: RTL
=====================

Name: ip_fifo_ctrl_mch

Overview:
- Single-clock, multi-channel FIFO controller.
- One shared RAM is split into NCH equal partitions of CH_DEP entries. Each partition has its own write/read pointers, full/empty flags, level and programmable watermarks.
- Sits between N producer streams and one shared single-port-write/single-port-read buffer RAM, e.g. per-lane line buffers or DMA queues.
- Generalises the single-channel controller with channel count, watermarks, per-channel flush and sticky error flags.

Parameters:
- NCH, 4: number of channels; 1 to 16.
- CH_DEP, 16: entries per channel; power of 2, at least 2.
- CH_AW, log2(CH_DEP): per-channel address width; derived, do not override.
- CH_W, max(1, log2(NCH)): channel index width; derived.

Ports:
- wclk  in  1  clock
- wrst_n  in  1  synchronous active-low reset, sampled on wclk rising edge
- push  in  1  write request
- push_ch  in  CH_W  channel index for push
- pop  in  1  read request
- pop_ch  in  CH_W  channel index for pop
- flush  in  NCH  per-channel flush; bit i clears channel i
- afull_th  in  CH_AW+1  almost-full threshold, shared by all channels
- aempty_th  in  CH_AW+1  almost-empty threshold, shared by all channels
- wen  out  1  RAM write enable (accepted push)
- waddr  out  CH_W+CH_AW  RAM write address = {push_ch, local wr ptr}
- ren  out  1  RAM read enable (accepted pop)
- raddr  out  CH_W+CH_AW  RAM read address = {pop_ch, local rd ptr}
- ff_full  out  NCH  per-channel full, registered
- ff_empty  out  NCH  per-channel empty, registered
- ff_afull  out  NCH  per-channel level >= afull_th, registered
- ff_aempty  out  NCH  per-channel level <= aempty_th, registered
- ff_lvl  out  NCH*(CH_AW+1)  packed per-channel levels; channel i at [i*(CH_AW+1) +: CH_AW+1]
- ovf  out  NCH  sticky overflow per channel
- udf  out  NCH  sticky underflow per channel

Behaviour:
- Reset (wrst_n=0 at wclk edge): all pointers 0, ff_lvl 0, ff_empty all 1, ff_aempty all 1, ff_full/ff_afull/ovf/udf all 0. Reset takes effect mid-operation in one cycle; in-flight requests in that cycle are dropped.
- Pointers: CH_AW+1 bits each, with a wrap bit. Local address is ptr[CH_AW-1:0] and wraps naturally modulo CH_DEP.
- Channel full: wrap bits differ and addresses are equal. Channel empty: pointers are equal.
- Push acceptance: wen = push & ~ff_full[push_ch] & ~flush[push_ch]. This is combinational, from registered flags. waddr uses the pre-increment pointer. The pointer increments at the next edge.
- Pop acceptance: ren = pop & ~ff_empty[pop_ch] & ~flush[pop_ch]. raddr uses the pre-increment pointer.
- No bypass:
  - Push to an empty channel is not poppable until the next cycle.
  - Push to a full channel is rejected even if the same channel pops in the same cycle.
- Rejected push (channel full, no flush) sets ovf[push_ch]. Rejected pop (channel empty, no flush) sets udf[pop_ch]. Both flags are sticky until flush or reset.
- Flush[i]: at the next edge, channel i pointers go to 0, level to 0, empty=1, aempty=1, full=0, afull=0, ovf[i]=0, udf[i]=0. Flush beats a push or pop on the same channel in the same cycle; the request is discarded and no error flag is set. Other channels are unaffected.
- Level update per channel i:
  - lvl_nxt = lvl + (wen & push_ch==i) - (ren & pop_ch==i).
  - Push and pop to the same channel in one cycle leave the level unchanged, and both pointers advance.
  - Range is 0..CH_DEP.
- All flags are computed from lvl_nxt and registered, giving 1-cycle latency from an accepted request to the flag update.
  - ff_afull = (lvl_nxt >= afull_th).
  - ff_aempty = (lvl_nxt <= aempty_th).
  - Threshold changes take effect on the next edge.
- No-request cycles hold all state.
- Push and pop to different channels in the same cycle are fully independent.
- SVA (non-synthesis):
  - ff_full[i] and ff_empty[i] never both 1.
  - ff_lvl[i] <= CH_DEP.
  - wen implies ~ff_full[push_ch].

Test Plan:
- Reset, then fill ch2 with 16 pushes (defaults) -> waddr runs 0x20..0x2F; after the 16th push ff_full[2]=1 and lvl2=16; 17th push gives wen=0 and ovf[2]=1; other channels stay empty.
- Fill ch1, then drain it with 16 pops, then pop once more -> raddr runs 0x10..0x1F; ff_empty[1]=1 one cycle after the last pop; extra pop gives ren=0 and udf[1]=1.
- Ch0 at lvl=8: simultaneous push and pop on ch0 for 20 cycles -> lvl stays 8; pointers wrap past 15 back to 0 and addresses stay correct.
- afull_th=12, aempty_th=3: push ch3 from 0 to 12 -> ff_aempty[3] clears when lvl=4, ff_afull[3] sets when lvl=12, each 1 cycle after the causing push.
- Ch1 at lvl=5 with ovf[1]=1: flush[1] with push on ch1 in the same cycle -> wen=0; next cycle lvl1=0, empty=1, ovf[1]=0; ch0 state unchanged.
- Reset asserted mid-traffic with ch0 lvl=7 -> next cycle all levels 0, ff_empty=all 1, ovf/udf=0, wen/ren=0 in the reset cycle.

Source files
------------

// File: rtl/ip_fifo_ctrl_mch.sv
// Multi-channel FIFO controller: one shared RAM split into NCH partitions of CH_DEP
// entries, each with its own pointers, level, full/empty/watermark flags and sticky errors.
module ip_fifo_ctrl_mch #(
  parameter  int NCH    = 4,
  parameter  int CH_DEP = 16,
  localparam int CH_AW  = $clog2(CH_DEP),
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic                    push,
  input  logic [CH_W-1:0]         push_ch,
  input  logic                    pop,
  input  logic [CH_W-1:0]         pop_ch,
  input  logic [NCH-1:0]          flush,
  input  logic [CH_AW:0]          afull_th,
  input  logic [CH_AW:0]          aempty_th,
  output logic                    wen,
  output logic [CH_W+CH_AW-1:0]   waddr,
  output logic                    ren,
  output logic [CH_W+CH_AW-1:0]   raddr,
  output logic [NCH-1:0]          ff_full,
  output logic [NCH-1:0]          ff_empty,
  output logic [NCH-1:0]          ff_afull,
  output logic [NCH-1:0]          ff_aempty,
  output logic [NCH*(CH_AW+1)-1:0] ff_lvl,
  output logic [NCH-1:0]          ovf,
  output logic [NCH-1:0]          udf
);

  localparam int LW    = CH_AW + 1;
  localparam int NCH_P = 1 << CH_W;
  localparam logic [LW-1:0] DEP_L = LW'(CH_DEP);

  logic [CH_AW:0]   wr_ptr [NCH_P];
  logic [CH_AW:0]   rd_ptr [NCH_P];
  logic [NCH_P-1:0] full_x, empty_x, flush_x;
  logic [NCH_P-1:0] push_oh, pop_oh, ovf_set, udf_set;
  logic [LW-1:0]    lvl_nxt [NCH];

  // Channel indices beyond NCH look permanently full and empty, so requests to them are refused.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    full_x  = '1;
    empty_x = '1;
    flush_x = '0;
    full_x[NCH-1:0]  = ff_full;
    empty_x[NCH-1:0] = ff_empty;
    flush_x[NCH-1:0] = flush;
  end

  // Acceptance uses only registered flags: no bypass between push and pop in one cycle.
  assign wen   = wrst_n & push & ~full_x[push_ch]  & ~flush_x[push_ch];
  assign ren   = wrst_n & pop  & ~empty_x[pop_ch]  & ~flush_x[pop_ch];
  assign waddr = {push_ch, wr_ptr[push_ch][CH_AW-1:0]};
  assign raddr = {pop_ch,  rd_ptr[pop_ch][CH_AW-1:0]};

  assign push_oh = NCH_P'(wen) << push_ch;
  assign pop_oh  = NCH_P'(ren) << pop_ch;
  assign ovf_set = NCH_P'(push & full_x[push_ch] & ~flush_x[push_ch]) << push_ch;
  assign udf_set = NCH_P'(pop & empty_x[pop_ch] & ~flush_x[pop_ch]) << pop_ch;

  always_comb begin
    for (int i = 0; i < NCH; i++)
      lvl_nxt[i] = ff_lvl[i*LW +: LW] + LW'(push_oh[i]) - LW'(pop_oh[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      for (int i = 0; i < NCH_P; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      ff_lvl    <= '0;
      ff_full   <= '0;
      ff_empty  <= '1;
      ff_afull  <= '0;
      ff_aempty <= '1;
      ovf       <= '0;
      udf       <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i]) begin
          wr_ptr[i]            <= '0;
          rd_ptr[i]            <= '0;
          ff_lvl[i*LW +: LW]   <= '0;
          ff_full[i]           <= 1'b0;
          ff_empty[i]          <= 1'b1;
          ff_afull[i]          <= 1'b0;
          ff_aempty[i]         <= 1'b1;
          ovf[i]               <= 1'b0;
          udf[i]               <= 1'b0;
        end else begin
          if (push_oh[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop_oh[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          ff_lvl[i*LW +: LW] <= lvl_nxt[i];
          ff_full[i]         <= (lvl_nxt[i] == DEP_L);
          ff_empty[i]        <= (lvl_nxt[i] == '0);
          ff_afull[i]        <= (lvl_nxt[i] >= afull_th);
          ff_aempty[i]       <= (lvl_nxt[i] <= aempty_th);
          ovf[i]             <= ovf[i] | ovf_set[i];
          udf[i]             <= udf[i] | udf_set[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_sva
    a_full_empty : assert property (@(posedge wclk) disable iff (!wrst_n)
      !(ff_full[g] && ff_empty[g]));
    a_lvl_range : assert property (@(posedge wclk) disable iff (!wrst_n)
      ff_lvl[g*LW +: LW] <= DEP_L);
  end
  a_wen_not_full : assert property (@(posedge wclk) disable iff (!wrst_n)
    wen |-> !full_x[push_ch]);

endmodule
